fir_stream_fifo: RTL

//  AXI-Stream output buffer placed directly downstream of the FIR core's sm_* master port.

---
 rtl/fir_stream_fifo.sv | 132 +++++++++++++
 1 files changed

// File: rtl/fir_stream_fifo.sv
// -----------------------------------------------------------------------------
// fir_stream_fifo
//   AXI-Stream output buffer that sits directly after the FIR core's sm_* master
//   port. It decouples FIR output timing from a slow or stalling sink.
//   The storage is a register-based first-word-fall-through FIFO. Each entry
//   keeps its tlast bit. The block also reports occupancy, counts the beats of
//   the frame currently leaving, and pulses frame_done once a frame's last beat
//   has left.
//
// Ports
//   axis_clk    in   clock for all logic
//   axis_rst_n  in   asynchronous active-low reset
//   clear       in   synchronous flush (highest priority), drops all contents
//   s_tvalid    in   upstream beat valid        (FIR sm_tvalid)
//   s_tdata     in   upstream data              (FIR sm_tdata)
//   s_tlast     in   upstream last              (FIR sm_tlast)
//   s_tready    out  space available            (to FIR sm_tready)
//   m_tvalid    out  downstream beat valid
//   m_tdata     out  downstream data (head of FIFO)
//   m_tlast     out  downstream last (head of FIFO)
//   m_tready    in   downstream accepts
//   level       out  entries currently held, 0..pDEPTH
//   beat_cnt    out  output beats of the current frame (saturating)
//   frame_done  out  1-cycle pulse in the cycle after a tlast beat leaves
//
// Handshake: a beat moves on an interface only on a clock edge where both valid
// and ready are high. push = s_tvalid & s_tready, pop = m_tvalid & m_tready.
// A valid beat never changes or drops while it waits for ready.
// s_tready depends only on registers. It has no combinational path from
// m_tready, so a full FIFO refuses a push even in a cycle where it pops.
// -----------------------------------------------------------------------------
module fir_stream_fifo #(
  parameter int pDATA_WIDTH = 32,
  parameter int pDEPTH      = 8,
  parameter int pLVL_WIDTH  = 4
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   clear,
  input  logic                   s_tvalid,
  input  logic [pDATA_WIDTH-1:0] s_tdata,
  input  logic                   s_tlast,
  output logic                   s_tready,
  output logic                   m_tvalid,
  output logic [pDATA_WIDTH-1:0] m_tdata,
  output logic                   m_tlast,
  input  logic                   m_tready,
  output logic [pLVL_WIDTH-1:0]  level,
  output logic [31:0]            beat_cnt,
  output logic                   frame_done
);

  localparam int AW = $clog2(pDEPTH);

  // Pointers carry one extra wrap bit. This tells full and empty apart.
  logic [AW:0]            r_wptr;
  logic [AW:0]            r_rptr;
  logic [pDATA_WIDTH-1:0] r_mem_data [pDEPTH];
  logic [pDEPTH-1:0]      r_mem_last;
  logic                   r_first;      // next pop starts a new frame
  logic [31:0]            r_beat_cnt;
  logic                   r_frame_done;

  logic                   w_empty;
  logic                   w_full;
  logic                   w_push;
  logic                   w_pop;
  logic [AW:0]            w_level;
  logic [AW-1:0]          w_widx;
  logic [AW-1:0]          w_ridx;

  assign w_widx  = r_wptr[AW-1:0];
  assign w_ridx  = r_rptr[AW-1:0];
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (w_widx == w_ridx);
  assign w_push  = s_tvalid & ~w_full;
  assign w_pop   = ~w_empty & m_tready;
  assign w_level = r_wptr - r_rptr;

  assign s_tready   = ~w_full;
  assign m_tvalid   = ~w_empty;
  assign m_tdata    = r_mem_data[w_ridx];
  assign m_tlast    = r_mem_last[w_ridx];
  assign level      = pLVL_WIDTH'(w_level);
  assign beat_cnt   = r_beat_cnt;
  assign frame_done = r_frame_done;

  // Storage. Entries are cleared on reset, so the head reads 0 while in reset.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      for (int i = 0; i < pDEPTH; i++) begin
        r_mem_data[i] <= '0;
      end
      r_mem_last <= '0;
    end else if (!clear && w_push) begin
      r_mem_data[w_widx] <= s_tdata;
      r_mem_last[w_widx] <= s_tlast;
    end
  end

  // Pointers, frame beat counter and frame_done pulse.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_first      <= 1'b1;
      r_beat_cnt   <= '0;
      r_frame_done <= 1'b0;
    end else if (clear) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_first      <= 1'b1;
      r_beat_cnt   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr  <= r_rptr + 1'b1;
        r_first <= m_tlast;
        if (r_first) begin
          r_beat_cnt <= 32'd1;
        end else if (r_beat_cnt != 32'hFFFF_FFFF) begin
          r_beat_cnt <= r_beat_cnt + 32'd1;
        end
      end
      r_frame_done <= w_pop & m_tlast;
    end
  end

endmodule
